if_id_buffer: RTL and testbench

//  Two-entry skid buffer forming the IF/ID pipeline boundary. It accepts {pc, instr} pairs from the

---
 rtl/if_id_buffer.sv | 107 ++++++++++
 tb/tb_if_id_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// IF/ID pipeline boundary: two-entry skid buffer with flush and instruction predecode.
// Optional IFID_STATS_EN adds saturating stall/flush counters on extra output ports.
module if_id_buffer #(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          CNT_W     = 16,
  parameter logic [DATA_W-1:0]    NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [3:0]        out_opcode,
  output logic [5:0]        out_rd,
  output logic [5:0]        out_rs,
  output logic [5:0]        out_rt
`ifdef IFID_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state;
  logic [DATA_W-1:0] main_pc, main_instr;
  logic [DATA_W-1:0] skid_pc, skid_instr;
  logic              push, pop;

  // in_ready depends only on the state register and rst, never on out_ready.
  always_comb begin
    in_ready  = !rst && (state != FULL);
    out_valid = (state != EMPTY);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_pc    = main_pc;
    out_instr = out_valid ? main_instr : NOP_INSTR;
  end

  assign out_opcode = out_instr[31:28];
  assign out_rd     = out_instr[27:22];
  assign out_rs     = out_instr[21:16];
  assign out_rt     = out_instr[15:10];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      // Same-cycle push is dropped; a same-cycle pop needs no state of its own.
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state      <= ONE;
            main_pc    <= in_pc;
            main_instr <= in_instr;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_pc    <= in_pc;
            main_instr <= in_instr;
          end else if (push) begin
            state      <= FULL;
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state      <= ONE;
            main_pc    <= skid_pc;
            main_instr <= skid_instr;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef IFID_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1)                  flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed vector bench for if_id_buffer plus a scoreboarded stream sequence.
// Counter checks are compiled in when IFID_STATS_EN is defined.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_instr = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_instr;
  logic [3:0]  out_opcode;
  logic [5:0]  out_rd, out_rs, out_rt;
`ifdef IFID_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  if_id_buffer #(.DATA_W(32), .CNT_W(16), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt)
`ifdef IFID_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int applied = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs driven for one cycle, and outputs expected during that same cycle (before its edge).
  typedef struct {
    logic        rst, iv;
    logic [31:0] pc, ins;
    logic        fl, ordy;
    logic        chk_out;
    logic        e_rdy, e_val;
    logic [31:0] e_pc, e_ins;
  } vec_t;

  localparam int NV = 26;
  vec_t v[NV];

  function automatic vec_t mk(input logic r, iv, input logic [31:0] pc, ins, input logic fl, ordy,
                              input logic co, er, ev, input logic [31:0] ep, ei);
    vec_t t;
    t.rst = r; t.iv = iv; t.pc = pc; t.ins = ins; t.fl = fl; t.ordy = ordy;
    t.chk_out = co; t.e_rdy = er; t.e_val = ev; t.e_pc = ep; t.e_ins = ei;
    return t;
  endfunction

  logic [31:0] q[$];
  logic [31:0] qpc[$];

  initial begin
    // reset
    v[0]  = mk(1, 0, 32'h0,  32'h0,         0, 0, 0, 0, 0, 32'h0,  32'h0);
    v[1]  = mk(1, 0, 32'h0,  32'h0,         0, 0, 1, 0, 0, 32'h0,  32'h0);
    v[2]  = mk(0, 0, 32'h0,  32'h0,         0, 0, 1, 1, 0, 32'h0,  32'h0);
    // streaming with out_ready=1
    v[3]  = mk(0, 1, 32'h0,  32'hA,         0, 1, 1, 1, 0, 32'h0,  32'h0);
    v[4]  = mk(0, 1, 32'h4,  32'hB,         0, 1, 1, 1, 1, 32'h0,  32'hA);
    v[5]  = mk(0, 1, 32'h8,  32'hC,         0, 1, 1, 1, 1, 32'h4,  32'hB);
    v[6]  = mk(0, 0, 32'h0,  32'h0,         0, 1, 1, 1, 1, 32'h8,  32'hC);
    v[7]  = mk(0, 0, 32'h0,  32'h0,         0, 1, 1, 1, 0, 32'h8,  32'h0);
    // back-pressure
    v[8]  = mk(0, 1, 32'h0,  32'h11,        0, 0, 1, 1, 0, 32'h8,  32'h0);
    v[9]  = mk(0, 1, 32'h4,  32'h22,        0, 0, 1, 1, 1, 32'h0,  32'h11);
    v[10] = mk(0, 1, 32'h8,  32'h33,        0, 0, 1, 0, 1, 32'h0,  32'h11);
    v[11] = mk(0, 1, 32'h8,  32'h33,        0, 1, 1, 0, 1, 32'h0,  32'h11);
    v[12] = mk(0, 1, 32'h8,  32'h33,        0, 1, 1, 1, 1, 32'h4,  32'h22);
    v[13] = mk(0, 0, 32'h0,  32'h0,         0, 1, 1, 1, 1, 32'h8,  32'h33);
    v[14] = mk(0, 0, 32'h0,  32'h0,         0, 1, 1, 1, 0, 32'h8,  32'h0);
    // flush while FULL, then flush with a push and a pop in the same cycle
    v[15] = mk(0, 1, 32'h10, 32'h55,        0, 0, 1, 1, 0, 32'h8,  32'h0);
    v[16] = mk(0, 1, 32'h14, 32'h66,        0, 0, 1, 1, 1, 32'h10, 32'h55);
    v[17] = mk(0, 1, 32'h18, 32'h44,        1, 0, 1, 0, 1, 32'h10, 32'h55);
    v[18] = mk(0, 0, 32'h0,  32'h0,         0, 0, 1, 1, 0, 32'h10, 32'h0);
    v[19] = mk(0, 1, 32'h20, 32'h77,        0, 0, 1, 1, 0, 32'h10, 32'h0);
    v[20] = mk(0, 1, 32'h24, 32'h44,        1, 1, 1, 1, 1, 32'h20, 32'h77);
    v[21] = mk(0, 0, 32'h0,  32'h0,         0, 0, 1, 1, 0, 32'h20, 32'h0);
    // predecode word
    v[22] = mk(0, 1, 32'h30, 32'h5A5A_5A5A, 0, 0, 1, 1, 0, 32'h20, 32'h0);
    v[23] = mk(0, 0, 32'h0,  32'h0,         0, 0, 1, 1, 1, 32'h30, 32'h5A5A_5A5A);
    // mid-stream reset behaves like flush and clears the data registers
    v[24] = mk(1, 1, 32'h40, 32'h99,        0, 0, 1, 0, 1, 32'h30, 32'h5A5A_5A5A);
    v[25] = mk(0, 0, 32'h0,  32'h0,         0, 0, 1, 1, 0, 32'h0,  32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = v[i].rst; in_valid = v[i].iv; in_pc = v[i].pc; in_instr = v[i].ins;
      flush = v[i].fl; out_ready = v[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, v[i].e_rdy});
      if (v[i].chk_out) begin
        chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, v[i].e_val});
        chk($sformatf("v%0d out_pc", i), out_pc, v[i].e_pc);
        chk($sformatf("v%0d out_instr", i), out_instr, v[i].e_ins);
      end
      if (i == 23) begin
        chk("opcode", {28'b0, out_opcode}, 32'h5);
        chk("rd",     {26'b0, out_rd},     32'h29);
        chk("rs",     {26'b0, out_rs},     32'h1A);
        chk("rt",     {26'b0, out_rt},     32'h16);
      end
    end

    // Scoreboarded stream with irregular valid/ready patterns: order and occupancy.
    begin
      int unsigned idx = 0;
      logic mpush, mpop;
      for (int c = 0; c < 70; c++) begin
        @(negedge clk);
        rst = 0; flush = 0;
        in_valid  = (c < 60) ? ($urandom_range(0, 3) != 0) : 1'b0;
        out_ready = (c < 60) ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_pc = idx * 4; in_instr = 32'h1000 + idx;
        #1;
        chk($sformatf("s%0d in_ready", c), {31'b0, in_ready}, {31'b0, (q.size() < 2)});
        chk($sformatf("s%0d out_valid", c), {31'b0, out_valid}, {31'b0, (q.size() > 0)});
        mpush = in_valid && (q.size() < 2);
        mpop  = out_ready && (q.size() > 0);
        if (q.size() > 0) begin
          chk($sformatf("s%0d out_instr", c), out_instr, q[0]);
          chk($sformatf("s%0d out_pc", c), out_pc, qpc[0]);
        end
        if (mpop) begin void'(q.pop_front()); void'(qpc.pop_front()); end
        if (mpush) begin q.push_back(32'h1000 + idx); qpc.push_back(idx * 4); idx++; end
      end
      @(negedge clk);
      in_valid = 0; out_ready = 0;
      #1;
      chk("stream drained", {31'b0, out_valid}, 32'h0);
    end

`ifdef IFID_STATS_EN
    @(negedge clk); rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    @(negedge clk); rst = 0;
    #1;
    chk("stall_cnt reset", {16'b0, stall_cnt}, 32'h0);
    chk("flush_cnt reset", {16'b0, flush_cnt}, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); in_valid = 1;
    end
    @(negedge clk); in_valid = 0;
    #1;
    chk("stall_cnt 10 offers", {16'b0, stall_cnt}, 32'd8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); flush = 1;
      @(negedge clk); flush = 0;
    end
    #1;
    chk("flush_cnt 3 pulses", {16'b0, flush_cnt}, 32'd3);
    chk("stall_cnt after flush", {16'b0, stall_cnt}, 32'd8);
    in_valid = 1;
    for (int c = 0; c < 65540; c++) @(negedge clk);
    #1;
    chk("stall_cnt saturates", {16'b0, stall_cnt}, 32'h0000_FFFF);
    in_valid = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
